// File: rtl/fp8_recip_pipe.sv
// Two-stage FP8 E4M3 reciprocal pipeline with valid/ready flow control.
// Operand A and a sideband tag ride alongside so a downstream multiplier can form a/b.
module fp8_recip_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       operand_a_i,
  input  logic [7:0]       operand_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       operand_a_o,
  output logic [7:0]       recip_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [2:0]       flags_o,
  output logic [2:0]       sticky_o,
  input  logic             clr_sticky_i
);

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_NAN
  } cls_e;

  // Stage 1: decoded divisor plus passthrough fields
  logic             s1_valid_q, s1_valid_d;
  cls_e             s1_cls_q, s1_cls_d;
  logic             s1_sign_q;
  logic [3:0]       s1_exp_q;
  logic [2:0]       s1_mant_q;
  logic [7:0]       s1_a_q;
  logic [TAG_W-1:0] s1_tag_q;

  // Stage 2: final result
  logic             s2_valid_q, s2_valid_d;
  logic [7:0]       s2_recip_q, s2_recip_d;
  logic [2:0]       s2_flags_q, s2_flags_d;
  logic [7:0]       s2_a_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic [2:0]       sticky_q, sticky_d;

  logic s1_accept, s2_accept, s1_load, s2_load;

  // A stage can take new data when it is empty or its contents leave this cycle.
  assign s2_accept  = !s2_valid_q || out_ready_i;
  assign s1_accept  = !s1_valid_q || s2_accept;
  assign s1_load    = in_valid_i && s1_accept;
  assign s2_load    = s1_valid_q && s2_accept;
  assign in_ready_o = s1_accept;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_accept) s1_valid_d = in_valid_i;
    if (s2_accept) s2_valid_d = s1_valid_q;
  end

  always_comb begin
    s1_cls_d = CLS_NORM;
    if (operand_b_i[6:0] == 7'h7F)      s1_cls_d = CLS_NAN;
    else if (operand_b_i[6:3] == 4'd0)  s1_cls_d = CLS_ZERO;
  end

  // Mantissa of 16/(8+m), rounded to nearest; the m=0 case is an exact power of two.
  function automatic logic [2:0] recip_mant(input logic [2:0] m);
    logic [2:0] r;
    r = 3'd0;
    case (m)
      3'd1:    r = 3'd6;
      3'd2:    r = 3'd5;
      3'd3:    r = 3'd4;
      3'd4:    r = 3'd3;
      3'd5:    r = 3'd2;
      3'd6:    r = 3'd1;
      3'd7:    r = 3'd1;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    s2_recip_d = {s1_sign_q, 7'h00};
    s2_flags_d = 3'b000;
    case (s1_cls_q)
      CLS_NAN: begin
        s2_recip_d = {s1_sign_q, 7'h7F};
        s2_flags_d = 3'b100;
      end
      CLS_ZERO: begin
        s2_recip_d = {s1_sign_q, 7'h7E};
        s2_flags_d = 3'b010;
      end
      default: begin
        if (s1_mant_q == 3'd0) begin
          if (s1_exp_q >= 4'd14) s2_flags_d = 3'b001;
          else s2_recip_d = {s1_sign_q, 4'd14 - s1_exp_q, 3'd0};
        end else begin
          if (s1_exp_q >= 4'd13) s2_flags_d = 3'b001;
          else s2_recip_d = {s1_sign_q, 4'd13 - s1_exp_q, recip_mant(s1_mant_q)};
        end
      end
    endcase
  end

  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky_i)                    sticky_d = 3'b000;
    else if (s2_valid_q && out_ready_i)  sticky_d = sticky_q | s2_flags_q;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      sticky_q   <= 3'b000;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      sticky_q   <= sticky_d;
    end
  end

  // NOTE: payload registers carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    if (s1_load) begin
      s1_cls_q  <= s1_cls_d;
      s1_sign_q <= operand_b_i[7];
      s1_exp_q  <= operand_b_i[6:3];
      s1_mant_q <= operand_b_i[2:0];
      s1_a_q    <= operand_a_i;
      s1_tag_q  <= tag_i;
    end
    if (s2_load) begin
      s2_recip_q <= s2_recip_d;
      s2_flags_q <= s2_flags_d;
      s2_a_q     <= s1_a_q;
      s2_tag_q   <= s1_tag_q;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign recip_o     = s2_recip_q;
  assign flags_o     = s2_flags_q;
  assign operand_a_o = s2_a_q;
  assign tag_o       = s2_tag_q;
  assign sticky_o    = sticky_q;

endmodule
